// File: rtl/reset_pkg.sv
// -----------------------------------------------------------------------------
// reset_pkg
// Shared definitions for the reset sequencer:
//   - state_t       : 2-bit encoded sequencer state
//   - clog2_w()     : ceiling log2, usable in localparam width expressions
//   - DEASSERT_VAL  : level an active-low reset takes when released
// -----------------------------------------------------------------------------
package reset_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic DEASSERT_VAL = 1'b1;

    // Smallest w such that 2**w >= value; returns 0 for value <= 1.
    function automatic int clog2_w(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Groups the software reset request and the channel reset outputs.
//   SW_RST   : synchronous active-high software reset request
//   SYNC_RST : active-low channel resets, bit 0 released first
//   RST_DONE : high once every channel is released
// Modports: master (request side, observes resets), slave (the sequencer).
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int NUM_CH = 3
) ();

    logic              SW_RST;
    logic [NUM_CH-1:0] SYNC_RST;
    logic              RST_DONE;

    modport master (
        output SW_RST,
        input  SYNC_RST,
        input  RST_DONE
    );

    modport slave (
        input  SW_RST,
        output SYNC_RST,
        output RST_DONE
    );

endinterface

// File: rtl/reset_sync_chain.sv
// -----------------------------------------------------------------------------
// reset_sync_chain
// Asynchronous-assert / synchronous-deassert chain. A constant release level
// is shifted through NUM_STAGES flops; all flops clear the moment rst_ni falls.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   rst_ok_o : last stage, high NUM_STAGES edges after rst_ni returns high
// -----------------------------------------------------------------------------
module reset_sync_chain
    import reset_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_ok_o
);

    logic [NUM_STAGES-1:0] stage_q;

    // Shift the release level toward the output stage; clear asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[NUM_STAGES-2:0], DEASSERT_VAL};
        end
    end

    assign rst_ok_o = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Multi-channel reset controller. All channel resets assert asynchronously
// with RST, stay asserted for MIN_ASSERT cycles after the release condition,
// then release one channel every GAP cycles in index order. SW_RST re-runs
// the whole sequence synchronously.
//   CLK : system clock
//   RST : asynchronous active-low reset
//   bus : reset_sequencer_if slave (SW_RST in, SYNC_RST / RST_DONE out)
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 3,
    parameter int MIN_ASSERT = 4,
    parameter int GAP        = 2
) (
    input  logic         CLK,
    input  logic         RST,
    reset_sequencer_if.slave bus
);

    localparam int CNT_MAX = (MIN_ASSERT > GAP) ? MIN_ASSERT : GAP;
    localparam int CNT_W   = clog2_w(CNT_MAX + 1);
    localparam int IDX_W   = clog2_w(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0] LAST_CH      = IDX_W'(NUM_CH - 1);

    logic              rst_ok_s;
    logic              release_s;
    logic [NUM_CH-1:0] chan_shift_s;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] sync_rst_q, sync_rst_d;
    logic              rst_done_q, rst_done_d;
    logic              sw_path_q, sw_path_d;

    reset_sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_sync (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .rst_ok_o (rst_ok_s)
    );

    assign release_s = rst_ok_s & ~bus.SW_RST;

    // Channel vector with the next channel released; shifting a release level
    // in from bit 0 keeps the release order monotonic by construction.
    always_comb begin
        chan_shift_s    = sync_rst_q;
        chan_shift_s[0] = DEASSERT_VAL;
        for (int i = 1; i < NUM_CH; i++) begin
            chan_shift_s[i] = sync_rst_q[i-1];
        end
    end

    // Next-state, counter, channel and done logic; SW_RST overrides last.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sync_rst_d = sync_rst_q;
        rst_done_d = 1'b0;
        sw_path_d  = sw_path_q;

        case (state_q)
            ASSERT: begin
                sync_rst_d = '0;
                if (release_s) begin
                    // After a hardware reset the cycle in which rst_ok first
                    // reads high already counts toward the stretch; after a
                    // software request the full stretch starts at the first
                    // edge that samples the request low.
                    if (!sw_path_q && (MIN_ASSERT == 1)) begin
                        sync_rst_d = chan_shift_s;
                        cnt_d      = '0;
                        idx_d      = IDX_W'(1);
                        state_d    = (NUM_CH == 1) ? DONE : RELEASE;
                    end else begin
                        cnt_d   = sw_path_q ? CNT_W'(0) : CNT_W'(1);
                        idx_d   = '0;
                        state_d = STRETCH;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ASSERT;
                end
            end

            STRETCH: begin
                if (cnt_q == STRETCH_LAST) begin
                    sync_rst_d = chan_shift_s;
                    cnt_d      = '0;
                    idx_d      = IDX_W'(1);
                    state_d    = (NUM_CH == 1) ? DONE : RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    sync_rst_d = chan_shift_s;
                    cnt_d      = '0;
                    if (idx_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                rst_done_d = 1'b1;
            end

            default: begin
                state_d    = ASSERT;
                sync_rst_d = '0;
                cnt_d      = '0;
                idx_d      = '0;
            end
        endcase

        // A software request wins over any release scheduled on this edge.
        if (bus.SW_RST) begin
            state_d    = ASSERT;
            sync_rst_d = '0;
            rst_done_d = 1'b0;
            cnt_d      = '0;
            idx_d      = '0;
            sw_path_d  = 1'b1;
        end else begin
            sw_path_d = sw_path_q;
        end
    end

    // State, counters and registered outputs; everything clears on RST low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync_rst_q <= '0;
            rst_done_q <= 1'b0;
            sw_path_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync_rst_q <= sync_rst_d;
            rst_done_q <= rst_done_d;
            sw_path_q  <= sw_path_d;
        end
    end

    assign bus.SYNC_RST = sync_rst_q;
    assign bus.RST_DONE = rst_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Scoreboard bench: each driven edge pushes the expected SYNC_RST/RST_DONE
// (from a timing model built on the release-edge formulas) and the falling
// clock edge pops and compares. A second instance covers the single-channel,
// one-cycle stretch, three-stage configuration.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int NS  = 2;
    localparam int MA  = 4;
    localparam int GP  = 2;
    localparam int NCH = 3;

    localparam int NS1 = 3;
    localparam int MA1 = 1;

    typedef struct packed {
        logic [NCH-1:0] sync;
        logic           done;
    } exp_t;

    logic CLK      = 1'b0;
    logic rst_n_r  = 1'b0;
    logic rst1_n_r = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb_q[$];

    int edge_n;
    int base_e;
    bit sw_held;

    reset_sequencer_if #(.NUM_CH(NCH)) bus0 ();
    reset_sequencer_if #(.NUM_CH(1))   bus1 ();

    reset_sequencer #(
        .NUM_STAGES (NS),
        .NUM_CH     (NCH),
        .MIN_ASSERT (MA),
        .GAP        (GP)
    ) dut0 (
        .CLK (CLK),
        .RST (rst_n_r),
        .bus (bus0)
    );

    reset_sequencer #(
        .NUM_STAGES (NS1),
        .NUM_CH     (1),
        .MIN_ASSERT (MA1),
        .GAP        (GP)
    ) dut1 (
        .CLK (CLK),
        .RST (rst1_n_r),
        .bus (bus1)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        edge_n  = 0;
        base_e  = NS + MA;
        sw_held = 1'b0;
    endfunction

    // Expected outputs after the current edge, given the SW_RST it sampled.
    function automatic exp_t model_next(input logic sw);
        exp_t e;
        e = '0;
        if (sw) begin
            sw_held = 1'b1;
        end else if (sw_held) begin
            sw_held = 1'b0;
            base_e  = edge_n + MA;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                e.sync[k] = (edge_n >= base_e + k * GP);
            end
            e.done = (edge_n >= base_e + (NCH - 1) * GP + 1);
        end
        return e;
    endfunction

    function automatic logic is_thermo(input logic [NCH-1:0] v);
        logic [NCH:0] w;
        w = {1'b0, v};
        return ((w & (w + 1'b1)) == '0);
    endfunction

    task automatic tick(input logic sw, input bit glitch);
        int d;
        int w;
        bus0.SW_RST = sw;
        @(posedge CLK);
        edge_n++;
        sb_q.push_back(model_next(sw));
        @(negedge CLK);
        if (glitch) begin
            d = $urandom_range(2, 1);
            w = $urandom_range(2, 1);
            #(d);
            rst_n_r = 1'b0;
            #(w);
            rst_n_r = 1'b1;
            model_reset();
        end
    endtask

    task automatic pulse_rst();
        rst_n_r = 1'b0;
        #2;
        rst_n_r = 1'b1;
        model_reset();
    endtask

    // Pop the expectation for the last edge and compare away from the edge.
    always @(negedge CLK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("sync_rst", 8'(bus0.SYNC_RST), 8'(e.sync));
            check_val("rst_done", 8'(bus0.RST_DONE), 8'(e.done));
            check_val("monotonic", 8'(is_thermo(bus0.SYNC_RST)), 8'd1);
        end
    end

    initial begin
        bus0.SW_RST = 1'b0;
        bus1.SW_RST = 1'b0;
        model_reset();

        #1;
        check_val("reset_sync", 8'(bus0.SYNC_RST), 8'd0);
        check_val("reset_done", 8'(bus0.RST_DONE), 8'd0);
        #1;
        rst_n_r  = 1'b1;
        rst1_n_r = 1'b1;

        // Power-on sequence, plus the single-channel instance alongside.
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            check_val("ch1_sync", 8'(bus1.SYNC_RST), 8'(edge_n >= NS1 + MA1));
            check_val("ch1_done", 8'(bus1.RST_DONE), 8'(edge_n >= NS1 + MA1 + 1));
        end

        // RST low mid-cycle after edge 9 must clear outputs without a clock.
        pulse_rst();
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b0);
        end
        rst_n_r = 1'b0;
        #1;
        check_val("async_sync", 8'(bus0.SYNC_RST), 8'd0);
        check_val("async_done", 8'(bus0.RST_DONE), 8'd0);
        #1;
        rst_n_r = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
        end

        // Software reset from DONE, held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
        end

        // Software reset landing in RELEASE at edge 7, held for six edges.
        pulse_rst();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
        end

        // Software reset on the last release edge (edge 10): assert wins.
        pulse_rst();
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b0);
        end
        tick(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
        end

        // Random sub-cycle RST glitches.
        pulse_rst();
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, ($urandom_range(7, 0) == 0));
        end

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
